// File: rtl/pc2drone_pkg.sv
// Shared types and constants for the Pc2Drone command path.
package pc2drone_pkg;

   localparam int unsigned PID_W  = 15;
   localparam int unsigned DIV_W  = 14;
   localparam int unsigned BYTE_W = 8;

   localparam int unsigned PID_MAX = 12240;
   localparam int unsigned CMD_DIV = 48;
   localparam logic [BYTE_W-1:0] FRAME_HEADER = 8'hFF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIV_X,
      S_DIV_Y,
      S_SEND
   } state_t;

   // Clamp a signed PID sample into 0..max_in.
   function automatic logic [DIV_W-1:0] clamp_pid(input logic signed [PID_W-1:0] v,
                                                  input logic [DIV_W-1:0] max_in);
      if (v < 0)
         return '0;
      else if (v > $signed({1'b0, max_in}))
         return max_in;
      else
         return v[DIV_W-1:0];
   endfunction

   // A data byte must never alias the frame header.
   function automatic logic [BYTE_W-1:0] scale_fix(input logic [BYTE_W-1:0] q);
      return (q == 8'hFF) ? 8'hFE : q;
   endfunction

endpackage

// File: rtl/div48_seq.sv
// Sequential restoring divide by CMD_DIV, one quotient bit per cycle, MSB first.
// A start on the final step cycle reloads the operands while the last bit of
// the previous quotient still shifts in, so quotient stays complete for one
// cycle after done even when a new divide begins immediately.
module div48_seq
   import pc2drone_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DIV_W-1:0]  dividend,
   output logic [BYTE_W-1:0] quotient,
   output logic              done
);

   localparam logic [DIV_W-1:0] DSR_TOP = DIV_W'(CMD_DIV << 7);

   logic [DIV_W-1:0] rem;
   logic [DIV_W-1:0] dsr;
   logic [2:0]       cnt;
   logic             active;
   logic             ge;

   assign ge   = (rem >= dsr);
   assign done = active && (cnt == 3'd7);

   // Operand load on start, otherwise one subtract-and-shift step per cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rem      <= '0;
         dsr      <= '0;
         cnt      <= '0;
         active   <= 1'b0;
         quotient <= '0;
      end else begin
         if (active)
            quotient <= {quotient[BYTE_W-2:0], ge};
         if (start) begin
            rem    <= dividend;
            dsr    <= DSR_TOP;
            cnt    <= '0;
            active <= 1'b1;
         end else if (active) begin
            if (ge)
               rem <= rem - dsr;
            dsr <= dsr >> 1;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7)
               active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pid_cmd_packer.sv
// Pairs X/Y PID outputs, scales each to a command byte and streams a framed
// packet to the UART transmitter over valid/ready.
// Build option PKT_CHECKSUM_EN: append chk = (qx ^ qy) & 8'h7F as a 4th byte.
module pid_cmd_packer
   import pc2drone_pkg::*;
#(
   parameter logic [7:0]  HEADER = FRAME_HEADER,
   parameter int unsigned MAX_IN = PID_MAX
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              x_valid,
   input  logic [PID_W-1:0]  x_pid,
   input  logic              y_valid,
   input  logic [PID_W-1:0]  y_pid,
   input  logic              tx_ready,
   output logic              tx_valid,
   output logic [BYTE_W-1:0] tx_data,
   output logic              busy,
   output logic [7:0]        overrun_cnt
);

`ifdef PKT_CHECKSUM_EN
   localparam logic [1:0] LAST_IDX = 2'd3;
`else
   localparam logic [1:0] LAST_IDX = 2'd2;
`endif
   localparam logic [DIV_W-1:0] CLAMP_MAX = DIV_W'(MAX_IN);

   state_t            state, state_n;
   logic [PID_W-1:0]  x_hold, y_hold;
   logic              x_pend, y_pend;
   logic [DIV_W-1:0]  y_snap, y_snap_n;
   logic [BYTE_W-1:0] qx, qx_n;
   logic [1:0]        idx, idx_n, byte_sel;
   logic              first_y, first_y_n;
   logic              tx_valid_n;
   logic [BYTE_W-1:0] tx_data_n;
   logic              snap, start;
   logic [DIV_W-1:0]  dividend;
   logic [BYTE_W-1:0] quotient, qy, next_byte;
   logic              done, ovr;

   div48_seq u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .dividend (dividend),
      .quotient (quotient),
      .done     (done)
   );

   assign qy  = scale_fix(quotient);
   assign ovr = ~snap & ((x_valid & x_pend) | (y_valid & y_pend));

   // Sample capture and overrun accounting, active in every state.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_hold      <= '0;
         y_hold      <= '0;
         x_pend      <= 1'b0;
         y_pend      <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         if (x_valid) x_hold <= x_pid;
         if (y_valid) y_hold <= y_pid;
         x_pend <= x_valid | (x_pend & ~snap);
         y_pend <= y_valid | (y_pend & ~snap);
         if (ovr && overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'd1;
      end
   end

   // Byte to present next: the current index when idle on the bus, else the following one.
   always_comb begin
      byte_sel  = tx_valid ? idx + 2'd1 : idx;
      next_byte = HEADER;
      case (byte_sel)
         2'd1:    next_byte = qx;
         2'd2:    next_byte = qy;
`ifdef PKT_CHECKSUM_EN
         2'd3:    next_byte = (qx ^ qy) & 8'h7F;
`endif
         default: next_byte = HEADER;
      endcase
   end

   // Next-state, divider sequencing and transmit register control.
   always_comb begin
      state_n    = state;
      idx_n      = idx;
      qx_n       = qx;
      y_snap_n   = y_snap;
      first_y_n  = 1'b0;
      tx_valid_n = tx_valid;
      tx_data_n  = tx_data;
      snap       = 1'b0;
      start      = 1'b0;
      dividend   = clamp_pid(x_hold, CLAMP_MAX);
      case (state)
         S_IDLE: begin
            if (x_pend && y_pend) begin
               snap     = 1'b1;
               start    = 1'b1;
               y_snap_n = clamp_pid(y_hold, CLAMP_MAX);
               state_n  = S_DIV_X;
            end
         end
         S_DIV_X: begin
            if (done) begin
               start     = 1'b1;
               dividend  = y_snap;
               first_y_n = 1'b1;
               state_n   = S_DIV_Y;
            end
         end
         S_DIV_Y: begin
            if (first_y)
               qx_n = scale_fix(quotient);
            if (done) begin
               idx_n   = 2'd0;
               state_n = S_SEND;
            end
         end
         S_SEND: begin
            if (!tx_valid) begin
               tx_valid_n = 1'b1;
               tx_data_n  = next_byte;
            end else if (tx_ready) begin
               if (idx == LAST_IDX) begin
                  tx_valid_n = 1'b0;
                  if (x_pend && y_pend) begin
                     snap     = 1'b1;
                     start    = 1'b1;
                     y_snap_n = clamp_pid(y_hold, CLAMP_MAX);
                     state_n  = S_DIV_X;
                  end else begin
                     state_n = S_IDLE;
                  end
               end else begin
                  idx_n     = idx + 2'd1;
                  tx_data_n = next_byte;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         idx      <= '0;
         qx       <= '0;
         y_snap   <= '0;
         first_y  <= 1'b0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         qx       <= qx_n;
         y_snap   <= y_snap_n;
         first_y  <= first_y_n;
         tx_valid <= tx_valid_n;
         tx_data  <= tx_data_n;
         busy     <= (state_n != S_IDLE);
      end
   end

endmodule

// File: tb/tb_pid_cmd_packer.sv
// Scoreboard bench for pid_cmd_packer: directed X/Y pairs, expected frames queued
// at stimulus time and checked by an independent byte monitor.
module tb_pid_cmd_packer;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               x_valid = 1'b0;
   logic               y_valid = 1'b0;
   logic signed [14:0] x_pid = '0;
   logic signed [14:0] y_pid = '0;
   logic               tx_ready = 1'b0;
   logic               tx_valid;
   logic [7:0]         tx_data;
   logic               busy;
   logic [7:0]         overrun_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];

   pid_cmd_packer dut (
      .clk         (clk),
      .reset       (reset),
      .x_valid     (x_valid),
      .x_pid       (x_pid),
      .y_valid     (y_valid),
      .y_pid       (y_pid),
      .tx_ready    (tx_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .busy        (busy),
      .overrun_cnt (overrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected frame for a pair of already-scaled command bytes.
   task automatic push_frame(input logic [7:0] qx, input logic [7:0] qy);
      exp_q.push_back(8'hFF);
      exp_q.push_back(qx);
      exp_q.push_back(qy);
`ifdef PKT_CHECKSUM_EN
      exp_q.push_back((qx ^ qy) & 8'h7F);
`endif
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic strobe_x(input logic signed [14:0] v);
      x_valid = 1'b1; x_pid = v;
      tick(1);
      x_valid = 1'b0;
   endtask

   task automatic strobe_y(input logic signed [14:0] v);
      y_valid = 1'b1; y_pid = v;
      tick(1);
      y_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int got = 0;
      tick(2);
      for (int k = 0; k < 300; k++) begin
         if (!busy && !tx_valid) begin got = 1; break; end
         tick(1);
      end
      check({name, "_done"}, got, 1);
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic wait_valid(input string name);
      int got = 0;
      for (int k = 0; k < 100; k++) begin
         if (tx_valid) begin got = 1; break; end
         tick(1);
      end
      check({name, "_valid"}, got, 1);
   endtask

   // Byte monitor: every accepted byte must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!reset && tx_valid && tx_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_byte", int'(tx_data), -1);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("frame_byte", int'(tx_data), int'(e));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int bad;
      int seen;

      tick(3);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun_cnt, 0);
      reset = 1'b0;
      tick(1);

      // Mid-scale X and full-scale Y, Y three cycles after X; latency from Y capture.
      tx_ready = 1'b1;
      push_frame(8'h7F, 8'hFE);
      strobe_x(15'sd6120);
      tick(2);
      strobe_y(15'sd12240);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         tick(1);
         if (tx_valid) begin lat = k; break; end
      end
      check("latency", lat, 18);
      check("first_byte_header", tx_data, 8'hFF);
      wait_idle("f1");
      check("f1_busy_low", busy, 0);

      // Clamp at both ends: negative -> 0, just under one step -> 0.
      push_frame(8'h00, 8'h00);
      strobe_x(-15'sd5);
      strobe_y(15'sd47);
      wait_idle("f2");

      // Exact one step and an over-range value clamped to the ceiling.
      push_frame(8'h01, 8'hFE);
      strobe_x(15'sd48);
      strobe_y(15'sd16000);
      wait_idle("f3");

      // Receiver stalls for 10 cycles while qx is presented.
      tx_ready = 1'b0;
      push_frame(8'h0A, 8'h14);
      strobe_x(15'sd480);
      strobe_y(15'sd960);
      wait_valid("stall");
      tx_ready = 1'b1;
      tick(1);
      tx_ready = 1'b0;
      check("stall_qx", tx_data, 8'h0A);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (!tx_valid || tx_data != 8'h0A) bad++;
         tick(1);
      end
      check("stall_hold", bad, 0);
      tx_ready = 1'b1;
      wait_idle("f4");

      // Three X samples before Y: two overruns, last X value wins.
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("ovr_clear", overrun_cnt, 0);
      strobe_x(15'sd100);
      strobe_x(15'sd200);
      strobe_x(15'sd960);
      check("ovr_cnt2", overrun_cnt, 2);
      push_frame(8'h14, 8'h0A);
      strobe_y(15'sd480);
      wait_idle("f5");
      check("ovr_cnt2_hold", overrun_cnt, 2);

      // Reset while qy waits: frame abandoned, nothing follows.
      tx_ready = 1'b0;
      strobe_x(15'sd4800);
      strobe_x(15'sd2400);
      check("ovr_cnt3", overrun_cnt, 3);
      strobe_y(15'sd1200);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h32);
      wait_valid("rst_mid");
      tx_ready = 1'b1;
      tick(2);
      tx_ready = 1'b0;
      check("qy_waiting", tx_data, 8'h19);
      check("qy_waiting_valid", tx_valid, 1);
      reset = 1'b1;
      tick(1);
      check("mid_rst_valid", tx_valid, 0);
      check("mid_rst_overrun", overrun_cnt, 0);
      check("mid_rst_busy", busy, 0);
      reset = 1'b0;
      tx_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (tx_valid || busy) seen++;
         tick(1);
      end
      check("no_resume", seen, 0);
      check("mid_rst_drained", exp_q.size(), 0);

      // A fresh pair after the abandoned frame goes out normally.
      push_frame(8'h0A, 8'h14);
      strobe_x(15'sd480);
      strobe_y(15'sd960);
      wait_idle("f6");
      check("final_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
